// File: rtl/id_decode_buf.sv
// Decode-stage front end: opcode classification into a one-hot immediate select, plus a
// two-entry skid buffer (head H, skid S) so EX back-pressure never reaches IF combinationally.
module id_decode_buf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [XLEN-1:0]  if_inst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic [4:0]       imm_ctrl_o,
  input  logic [XLEN-1:0]  imm_i,
  output logic             id_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  id_inst_o,
  output logic [XLEN-1:0]  id_pc_o,
  output logic [XLEN-1:0]  id_imm_o,
  output logic [4:0]       id_imm_ctrl_o,
  output logic             id_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      ctrl;
    logic            illegal;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            h_q, h_d, s_q, s_d, in_entry;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              illegal;
  logic              acc, pop;
  logic              load_h, load_s, h_from_s;

  // Decode sees if_inst_i every cycle, whether or not IF is presenting a valid instruction.
  always_comb begin
    imm_ctrl_o = 5'b00000;
    illegal    = 1'b0;
    case (if_inst_i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_ctrl_o = 5'b00001;
      7'b0100011:                                     imm_ctrl_o = 5'b00010;
      7'b1100011:                                     imm_ctrl_o = 5'b00100;
      7'b0110111, 7'b0010111:                         imm_ctrl_o = 5'b01000;
      7'b1101111:                                     imm_ctrl_o = 5'b10000;
      7'b0110011, 7'b0001111:                         imm_ctrl_o = 5'b00000;
      default:                                        illegal    = 1'b1;
    endcase
  end

  assign in_entry = '{inst: if_inst_i, pc: if_pc_i, imm: imm_i, ctrl: imm_ctrl_o,
                      illegal: illegal};

  assign if_ready_o = (state_q != StFull);
  assign id_valid_o = (state_q != StEmpty);
  assign acc        = if_valid_i & if_ready_o;
  assign pop        = id_valid_o & ex_ready_i;

  always_comb begin
    state_d  = state_q;
    load_h   = 1'b0;
    load_s   = 1'b0;
    h_from_s = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          load_h  = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (acc && !pop) begin
          load_s  = 1'b1;
          state_d = StFull;
        end else if (acc && pop) begin
          load_h  = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          h_from_s = 1'b1;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush discards anything accepted this cycle and empties the buffer.
    if (flush_i) begin
      state_d  = StEmpty;
      load_h   = 1'b0;
      load_s   = 1'b0;
      h_from_s = 1'b0;
    end
  end

  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (load_h) begin
      h_d = in_entry;
    end else if (h_from_s) begin
      h_d = s_q;
    end
    if (load_s) begin
      s_d = in_entry;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid_o && !ex_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      h_q     <= '0;
      s_q     <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
      stall_q <= stall_d;
    end
  end

  assign id_inst_o     = h_q.inst;
  assign id_pc_o       = h_q.pc;
  assign id_imm_o      = h_q.imm;
  assign id_imm_ctrl_o = h_q.ctrl;
  assign id_illegal_o  = h_q.illegal;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_id_decode_buf.sv
// Self-checking bench for id_decode_buf: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the decode buffer.
module tb_id_decode_buf;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  ctrl;
    logic        ill;
  } ent_t;

  logic        clk, rst_n, flush, if_valid, ex_ready;
  logic [31:0] if_inst, if_pc, imm;
  logic        if_ready_o, id_valid_o, id_illegal_o;
  logic [4:0]  imm_ctrl_o, id_imm_ctrl_o;
  logic [31:0] id_inst_o, id_pc_o, id_imm_o;
  logic [15:0] stall_cnt_o;

  int   tests = 0;
  int   failed = 0;
  ent_t mq[$];
  int unsigned mstall = 0;

  id_decode_buf #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready_o),
    .if_inst_i(if_inst), .if_pc_i(if_pc), .imm_ctrl_o(imm_ctrl_o), .imm_i(imm),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .id_imm_o(id_imm_o), .id_imm_ctrl_o(id_imm_ctrl_o), .id_illegal_o(id_illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {illegal, imm_ctrl} from the opcode table.
  function automatic logic [5:0] ref_dec(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h67, 7'h73: return 6'b0_00001;
      7'h23:                      return 6'b0_00010;
      7'h63:                      return 6'b0_00100;
      7'h37, 7'h17:               return 6'b0_01000;
      7'h6F:                      return 6'b0_10000;
      7'h33, 7'h0F:               return 6'b0_00000;
      default:                    return 6'b1_00000;
    endcase
  endfunction

  // Stand-in for the immediate generator using the RISC-V immediate formats.
  function automatic logic [31:0] gen_imm(input logic [31:0] i);
    logic [4:0] c;
    c = ref_dec(i[6:0]) & 6'h1F;
    if (c[0]) return {{20{i[31]}}, i[31:20]};
    if (c[1]) return {{20{i[31]}}, i[31:25], i[11:7]};
    if (c[2]) return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    if (c[3]) return {i[31:12], 12'h000};
    if (c[4]) return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    return 32'h0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic exr, input logic fl);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    imm      = gen_imm(inst);
    ex_ready = exr;
    flush    = fl;
    #1;
  endtask

  // Advance one clock and update the reference model.
  task automatic tick();
    logic acc, pop;
    logic [5:0] d;
    ent_t e;
    acc = if_valid && (mq.size() < 2);
    pop = (mq.size() > 0) && ex_ready;
    if ((mq.size() > 0) && !ex_ready && (mstall != 32'hFFFF)) mstall++;
    d = ref_dec(if_inst[6:0]);
    e = '{inst: if_inst, pc: if_pc, imm: imm, ctrl: d[4:0], ill: d[5]};
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mstall = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h0000006F, 32'h40, 1'b0, 1'b0);
    tests++;
    if ({id_valid_o, if_ready_o} !== 2'b01) begin
      failed++; $display("FAIL reset_hs: got %b want 01", {id_valid_o, if_ready_o});
    end
    tests++;
    if ({id_inst_o, id_pc_o, id_imm_o, id_imm_ctrl_o, id_illegal_o, stall_cnt_o} !== '0) begin
      failed++; $display("FAIL reset_zero: inst %h pc %h imm %h stall %h want 0",
                         id_inst_o, id_pc_o, id_imm_o, stall_cnt_o);
    end
    tests++;
    if (imm_ctrl_o !== 5'b10000) begin
      failed++; $display("FAIL reset_decode: got %b want 10000", imm_ctrl_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mstall = 0;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    tests++;
    if (imm_ctrl_o !== 5'b00001) begin
      failed++; $display("FAIL addi_ctrl: got %b want 00001", imm_ctrl_o);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, id_imm_o, id_pc_o, id_illegal_o, id_imm_ctrl_o} !==
        {1'b1, 32'hFFFFFFFF, 32'h100, 1'b0, 5'b00001}) begin
      failed++; $display("FAIL addi_out: got v%b imm %h pc %h ill %b want v1 ffffffff 100 0",
                         id_valid_o, id_imm_o, id_pc_o, id_illegal_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3];
    logic [31:0] imms  [3];
    logic [4:0]  ctrls [3];
    insts = '{32'h0080006F, 32'h00112423, 32'h12345037};
    imms  = '{32'h8, 32'h8, 32'h12345000};
    ctrls = '{5'b10000, 5'b00010, 5'b01000};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, insts[k], 32'h200 + 32'(4 * k), 1'b1, 1'b0);
      else       drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (k > 0) begin
        tests++;
        if ({id_valid_o, id_inst_o, id_imm_o, id_imm_ctrl_o} !==
            {1'b1, insts[k-1], imms[k-1], ctrls[k-1]}) begin
          failed++; $display("FAIL b2b_%0d: got v%b inst %h imm %h ctrl %b want %h %h %b", k - 1,
                             id_valid_o, id_inst_o, id_imm_o, id_imm_ctrl_o,
                             insts[k-1], imms[k-1], ctrls[k-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_order();
    logic [31:0] pend[$];
    logic [31:0] got[$];
    logic [31:0] want [4];
    want = '{32'h00A00093, 32'h00B00113, 32'h00C00193, 32'h00D00213};
    do_reset();
    for (int k = 0; k < 4; k++) pend.push_back(want[k]);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, pend[0], 32'h300, 1'b0, 1'b0);
      if (k == 2) begin
        tests++;
        if (if_ready_o !== 1'b0) begin
          failed++; $display("FAIL stall_ready: got %b want 0", if_ready_o);
        end
      end
      if (if_ready_o) void'(pend.pop_front());
      tick();
    end
    tests++;
    if (stall_cnt_o !== 16'd3) begin
      failed++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt_o);
    end
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (pend.size() > 0) drive(1'b1, pend[0], 32'h300, 1'b1, 1'b0);
      else                 drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (id_valid_o) got.push_back(id_inst_o);
      if (if_ready_o && pend.size() > 0) void'(pend.pop_front());
      tick();
    end
    tests++;
    if (got.size() != 4) begin
      failed++; $display("FAIL stall_drain: got %0d outputs want 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        failed++; $display("FAIL stall_order_%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b1);
    tests++;
    if ({id_valid_o, if_ready_o} !== 2'b10) begin
      failed++; $display("FAIL flush_full: got %b want 10", {id_valid_o, if_ready_o});
    end
    tick();
    drive(1'b1, 32'h00400093, 32'h40C, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, if_ready_o, stall_cnt_o} !== {2'b01, 16'd2}) begin
      failed++; $display("FAIL flush_empty: got v%b r%b stall %0d want v0 r1 stall 2",
                         id_valid_o, if_ready_o, stall_cnt_o);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, id_inst_o, id_pc_o} !== {1'b1, 32'h00400093, 32'h40C}) begin
      failed++; $display("FAIL flush_next: got v%b inst %h pc %h want 1 00400093 40c",
                         id_valid_o, id_inst_o, id_pc_o);
    end
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000007F, 32'h500, 1'b1, 1'b0);
    tests++;
    if (imm_ctrl_o !== 5'b00000) begin
      failed++; $display("FAIL illegal_ctrl: got %b want 00000", imm_ctrl_o);
    end
    tick();
    drive(1'b1, 32'h00B50533, 32'h504, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, id_illegal_o, id_imm_ctrl_o} !== 7'b1_1_00000) begin
      failed++; $display("FAIL illegal_flag: got %b want 1100000",
                         {id_valid_o, id_illegal_o, id_imm_ctrl_o});
    end
    tests++;
    if (imm_ctrl_o !== 5'b00000) begin
      failed++; $display("FAIL add_ctrl: got %b want 00000", imm_ctrl_o);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, id_illegal_o, id_inst_o} !== {2'b10, 32'h00B50533}) begin
      failed++; $display("FAIL add_legal: got v%b ill %b inst %h want 1 0 00b50533",
                         id_valid_o, id_illegal_o, id_inst_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h00100093, 32'h600, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200093, 32'h604, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    tests++;
    if ({id_valid_o, if_ready_o, stall_cnt_o} !== {2'b10, 16'd5}) begin
      failed++; $display("FAIL arst_pre: got v%b r%b stall %0d want v1 r0 stall 5",
                         id_valid_o, if_ready_o, stall_cnt_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({id_valid_o, if_ready_o, id_inst_o, id_pc_o, id_imm_o, stall_cnt_o} !==
        {2'b01, 96'h0, 16'h0}) begin
      failed++; $display("FAIL arst_now: got v%b r%b inst %h stall %0d want v0 r1 0 0",
                         id_valid_o, if_ready_o, id_inst_o, stall_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mstall = 0;
    drive(1'b1, 32'h12345037, 32'h700, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests++;
    if ({id_valid_o, id_imm_o, id_pc_o} !== {1'b1, 32'h12345000, 32'h700}) begin
      failed++; $display("FAIL arst_resume: got v%b imm %h pc %h want 1 12345000 700",
                         id_valid_o, id_imm_o, id_pc_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] r, inst;
    logic [5:0]  d;
    ent_t        exp_h, got_h;
    int          bad = 0;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      inst = r;
      if ($urandom_range(0, 9) < 8) inst[6:0] = ops[$urandom_range(0, 10)];
      drive($urandom_range(0, 9) < 7, inst, $urandom(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
      d = ref_dec(inst[6:0]);
      got_h = '{inst: id_inst_o, pc: id_pc_o, imm: id_imm_o, ctrl: id_imm_ctrl_o,
                ill: id_illegal_o};
      exp_h = (mq.size() > 0) ? mq[0] : got_h;
      tests++;
      if ({id_valid_o, if_ready_o, imm_ctrl_o, stall_cnt_o, got_h} !==
          {mq.size() > 0, mq.size() < 2, d[4:0], mstall[15:0], exp_h}) begin
        failed++;
        bad++;
        if (bad < 5)
          $display("FAIL rand_%0d: got v%b r%b ctrl %b stall %0d head %h want v%b r%b %b %0d %h",
                   c, id_valid_o, if_ready_o, imm_ctrl_o, stall_cnt_o, got_h,
                   mq.size() > 0, mq.size() < 2, d[4:0], mstall, exp_h);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 32'h00100093, 32'h800, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (65534) @(negedge clk);
    tests++;
    if (stall_cnt_o !== 16'hFFFE) begin
      failed++; $display("FAIL sat_near: got %h want fffe", stall_cnt_o);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (stall_cnt_o !== 16'hFFFF) begin
      failed++; $display("FAIL sat_hold: got %h want ffff", stall_cnt_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall_order();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
